// File: rtl/rv_id_ex.sv
// ID/EX pipeline register for RV32I R-type instructions: single-entry skid-free
// stage with EX/MEM and MEM/WB operand forwarding at capture and during stalls.
module rv_id_ex #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic [4:0]             id_rd_addr,
    input  logic [31:0]            id_rs1_data,
    input  logic [31:0]            id_rs2_data,
    input  logic [2:0]             id_funct3,
    input  logic                   id_funct7_r,
    input  logic                   mem_wr_en,
    input  logic [4:0]             mem_rd_addr,
    input  logic [31:0]            mem_rd_data,
    input  logic                   wb_wr_en,
    input  logic [4:0]             wb_rd_addr,
    input  logic [31:0]            wb_rd_data,
    input  logic                   flush,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [31:0]            ex_rs1,
    output logic [31:0]            ex_rs2,
    output logic [2:0]             ex_funct3,
    output logic                   ex_funct7_r,
    output logic [4:0]             ex_rd_addr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [4:0]  rs1_addr_q;
    logic [4:0]  rs2_addr_q;
    logic        transfer;
    logic        hold;
    logic [31:0] cap_rs1;
    logic [31:0] cap_rs2;
    logic [31:0] ref_rs1;
    logic [31:0] ref_rs2;

    // Operand source priority: x0 is hard zero, then the younger EX/MEM write,
    // then MEM/WB, then the supplied fallback value.
    function automatic logic [31:0] pick_src(
        input logic [4:0]  addr,
        input logic [31:0] fallback,
        input logic        m_en,
        input logic [4:0]  m_addr,
        input logic [31:0] m_data,
        input logic        w_en,
        input logic [4:0]  w_addr,
        input logic [31:0] w_data
    );
        logic [31:0] r;
        r = fallback;
        if (addr == 5'd0)
            r = '0;
        else if (m_en && (m_addr == addr))
            r = m_data;
        else if (w_en && (w_addr == addr))
            r = w_data;
        return r;
    endfunction

    assign id_ready = !ex_valid || ex_ready;
    assign transfer = id_valid && id_ready;
    assign hold     = ex_valid && !ex_ready;

    always_comb begin
        cap_rs1 = pick_src(id_rs1_addr, id_rs1_data, mem_wr_en, mem_rd_addr, mem_rd_data,
                           wb_wr_en, wb_rd_addr, wb_rd_data);
        cap_rs2 = pick_src(id_rs2_addr, id_rs2_data, mem_wr_en, mem_rd_addr, mem_rd_data,
                           wb_wr_en, wb_rd_addr, wb_rd_data);
        // Held operands re-snoop so a write retiring mid-stall is not lost.
        ref_rs1 = pick_src(rs1_addr_q, ex_rs1, mem_wr_en, mem_rd_addr, mem_rd_data,
                           wb_wr_en, wb_rd_addr, wb_rd_data);
        ref_rs2 = pick_src(rs2_addr_q, ex_rs2, mem_wr_en, mem_rd_addr, mem_rd_data,
                           wb_wr_en, wb_rd_addr, wb_rd_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_funct3   <= '0;
            ex_funct7_r <= 1'b0;
            ex_rd_addr  <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            stall_cnt   <= '0;
        end else begin
            if (hold && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;

            if (flush) begin
                ex_valid <= 1'b0;
            end else if (transfer) begin
                ex_valid    <= 1'b1;
                ex_rs1      <= cap_rs1;
                ex_rs2      <= cap_rs2;
                ex_funct3   <= id_funct3;
                ex_funct7_r <= id_funct7_r;
                ex_rd_addr  <= id_rd_addr;
                rs1_addr_q  <= id_rs1_addr;
                rs2_addr_q  <= id_rs2_addr;
            end else if (hold) begin
                ex_rs1 <= ref_rs1;
                ex_rs2 <= ref_rs2;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule
